// File: rtl/uninasoc_pkg.sv
// Platform-wide constants and types shared by the interrupt path.
// PLIC line map, default PLIC sizing and the gateway state encoding.
package uninasoc_pkg;

  localparam int unsigned PLIC_NUM_LINES = 32;
  localparam logic [PLIC_NUM_LINES-1:0] PLIC_EDGE_MASK = '0;

  localparam int unsigned PLIC_RESERVED_LINE = 0;
  localparam int unsigned PLIC_GPIO_IN_LINE  = 1;
  localparam int unsigned PLIC_GPIO_OUT_LINE = 2;
  localparam int unsigned PLIC_TIMER_LINE    = 3;
  localparam int unsigned PLIC_UART_LINE     = 4;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PENDING,
    GW_IN_SERVICE
  } irq_gw_state_t;

endpackage

// File: rtl/irq_gateway_arbiter_gateway.sv
// Single-line interrupt gateway: captures a level or rising edge, holds it
// pending until claimed, then blocks new requests until completion.
module irq_gateway
  import uninasoc_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic edge_mode_i,
  input  logic claim_grant_i,
  input  logic complete_hit_i,
  output logic pending_o
);

  irq_gw_state_t state_q, state_d;
  logic          src_prev_q, src_prev_d;
  logic          trigger;

  always_comb begin
    trigger    = edge_mode_i ? (src_i & ~src_prev_q) : src_i;
    src_prev_d = src_i;
    state_d    = state_q;
    case (state_q)
      GW_IDLE:       if (trigger)        state_d = GW_PENDING;
      GW_PENDING:    if (claim_grant_i)  state_d = GW_IN_SERVICE;
      GW_IN_SERVICE: if (complete_hit_i) state_d = GW_IDLE;
      default:                           state_d = GW_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= GW_IDLE;
      src_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_prev_q <= src_prev_d;
    end
  end

  assign pending_o = (state_q == GW_PENDING);

endmodule

// File: rtl/irq_gateway_arbiter.sv
// Interrupt sequencer: per-line gateways, enable mask, fixed-priority
// arbiter and the claim/complete handshake toward the core.
module irq_gateway_arbiter
  import uninasoc_pkg::*;
#(
  parameter int unsigned NUM_LINES = PLIC_NUM_LINES,
  parameter logic [31:0] EDGE_MASK = 32'(PLIC_EDGE_MASK),
  parameter int unsigned ID_WIDTH  = $clog2(NUM_LINES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_LINES-1:0] irq_src_i,
  input  logic                 enable_we_i,
  input  logic [NUM_LINES-1:0] enable_wdata_i,
  output logic [NUM_LINES-1:0] enable_o,
  output logic [NUM_LINES-1:0] pending_o,
  output logic                 ext_irq_o,
  input  logic                 claim_req_i,
  output logic                 claim_valid_o,
  output logic [ID_WIDTH-1:0]  claim_id_o,
  input  logic                 complete_req_i,
  input  logic [ID_WIDTH-1:0]  complete_id_i
);

  logic [NUM_LINES-1:0] enable_q, enable_d;
  logic [NUM_LINES-1:0] pending;
  logic [NUM_LINES-1:0] eligible;
  logic [NUM_LINES-1:1] grant;
  logic                 ext_irq_q, ext_irq_d;
  logic                 claim_valid_q, claim_valid_d;
  logic [ID_WIDTH-1:0]  claim_id_q, claim_id_d;
  logic [ID_WIDTH-1:0]  winner_id;
  logic                 winner_found;
  logic                 unused_bits;

  // Line 0 is reserved: its source and enable bits are never used.
  assign unused_bits = ^{irq_src_i[0], enable_wdata_i[0]};
  assign pending[0]  = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_LINES; gi++) begin : g_gw
      irq_gateway u_gw (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .src_i          (irq_src_i[gi]),
        .edge_mode_i    (EDGE_MASK[gi]),
        .claim_grant_i  (grant[gi]),
        .complete_hit_i (complete_req_i && (complete_id_i == ID_WIDTH'(gi))),
        .pending_o      (pending[gi])
      );
    end
  endgenerate

  assign eligible = pending & enable_q;

  always_comb begin
    winner_id    = '0;
    winner_found = 1'b0;
    grant        = '0;
    for (int i = 1; i < NUM_LINES; i++) begin
      if (eligible[i] && !winner_found) begin
        winner_found = 1'b1;
        winner_id    = ID_WIDTH'(i);
        grant[i]     = claim_req_i;
      end
    end
  end

  always_comb begin
    enable_d                = enable_q;
    if (enable_we_i) enable_d[NUM_LINES-1:1] = enable_wdata_i[NUM_LINES-1:1];
    enable_d[0]             = 1'b0;
    ext_irq_d               = |eligible;
    claim_valid_d           = claim_req_i;
    claim_id_d              = claim_req_i ? winner_id : claim_id_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      enable_q      <= '0;
      ext_irq_q     <= 1'b0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      enable_q      <= enable_d;
      ext_irq_q     <= ext_irq_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
    end
  end

  assign enable_o      = enable_q;
  assign pending_o     = pending;
  assign ext_irq_o     = ext_irq_q;
  assign claim_valid_o = claim_valid_q;
  assign claim_id_o    = claim_id_q;

endmodule
